// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   rx_state_e : receiver FSM state encoding (3-bit)
//   OVS        : oversample ticks per serial bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int OVS = 16;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running oversample tick generator: one clk-wide pulse every DVSR clocks.
// Parameters:
//   DVSR  : clk cycles per tick (>= 2)
// Ports:
//   clk   : in  - clock, rising edge
//   reset : in  - asynchronous, active-high
//   tick  : out - one-clk pulse every DVSR cycles
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DVSR = 163
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(DVSR);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CW'(DVSR - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(DVSR - 1));

endmodule : uart_baud_gen

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver front-end: synchronizes rx, oversamples it and assembles
// LSB-first frames into bytes for the downstream receive buffer.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// after the data bits (otherwise parity_err is tied low).
// Parameters:
//   DBIT    : data bits per frame
//   SB_TICK : oversample ticks in the stop bit
//   DVSR    : clk cycles per oversample tick (>= 2)
// Ports:
//   clk        : in  - clock, rising edge
//   reset      : in  - asynchronous, active-high
//   rx         : in  - serial line, idle high
//   rx_data    : out - last accepted byte, held until the next one
//   rx_done    : out - one-clk strobe, rx_data valid on the same cycle
//   frame_err  : out - one-clk strobe, stop bit sampled 0
//   parity_err : out - one-clk strobe, parity check failed
//   busy       : out - high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    import uart_pkg::*;

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            tick;
    logic            rx_meta;
    logic            rx_sync;
    rx_state_e       state;
    logic [3:0]      s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] b_reg;
`ifdef UART_RX_PARITY_EN
    logic            p_reg;
`endif

    uart_baud_gen #(.DVSR(DVSR)) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer; resets to the idle line level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            b_reg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_reg      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low every cycle and are raised only on the
            // single edge that completes a frame, giving one-clk pulses.
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (tick && !rx_sync) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt == 4'd7) begin
                            // Mid start bit: a line back at 1 was a glitch.
                            if (!rx_sync) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == 4'(OVS - 1)) begin
                            s_cnt <= '0;
                            b_reg <= {rx_sync, b_reg[DBIT-1:1]};
                            if (n_cnt == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s_cnt == 4'(OVS - 1)) begin
                            s_cnt <= '0;
                            p_reg <= rx_sync;
                            state <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s_cnt == 4'(SB_TICK - 1)) begin
                            state <= IDLE;
                            if (!rx_sync) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (^{b_reg, p_reg}) begin
                                parity_err <= 1'b1;
`endif
                            end else begin
                                rx_done <= 1'b1;
                                rx_data <= b_reg;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core (DVSR = 4, DBIT = 8, SB_TICK = 16).
// A line driver serializes frames; a monitor logs every strobe; a frame-level
// model predicts the outcome of each frame from its data, parity and stop bit.
// Honours UART_RX_PARITY_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int DVSR       = 4;
    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int BIT_CLK    = 16 * DVSR;
    localparam int CLK_PERIOD = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum int {EV_DONE = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int   checks   = 0;
    int   failures = 0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    logic [7:0] last_good = 8'h00;
    time  last_done_t = 0;
    int   width_err = 0;

    uart_rx_core #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    // Strobe monitor, sampling on the falling edge.
    initial begin
        logic prev_any;
        prev_any = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done) begin
                obs_q.push_back('{EV_DONE, rx_data});
                last_done_t = $time - CLK_PERIOD / 2;
            end
            if (frame_err)  obs_q.push_back('{EV_FERR, rx_data});
            if (parity_err) obs_q.push_back('{EV_PERR, rx_data});
            if ((int'(rx_done) + int'(frame_err) + int'(parity_err)) > 1) width_err++;
            if (prev_any && (rx_done || frame_err || parity_err)) width_err++;
            prev_any = rx_done || frame_err || parity_err;
        end
    end

    // Serialize one frame (called and returning at posedge + 1) and record the
    // outcome the frame must produce.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bit, output time t_edge);
        ev_t e;
        e.data = last_good;
        if (!stop_bit)                    e.kind = EV_FERR;
        else if (PAR_EN && ^{d, par_bit}) e.kind = EV_PERR;
        else begin
            e.kind    = EV_DONE;
            e.data    = d;
            last_good = d;
        end
        exp_q.push_back(e);

        rx = 1'b0;
        @(posedge clk);
        t_edge = $time;
        repeat (BIT_CLK - 1) @(posedge clk);
        #1;
        for (int i = 0; i < DBIT; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
        if (PAR_EN) begin
            rx = par_bit;
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_done, frame_err, parity_err, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold: outputs=%h required=000",
                     {rx_data, rx_done, frame_err, parity_err, busy});
        end
        reset = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_done, frame_err, parity_err, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_idle: outputs=%h required=000",
                     {rx_data, rx_done, frame_err, parity_err, busy});
        end
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_strobes: got %0d strobes, required 0", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_byte();
        time t_edge;
        int  lat;
        last_done_t = 0;
        send_frame(8'hA5, 1'b1, 1'b0, t_edge);
        lat = int'((last_done_t - t_edge) / CLK_PERIOD);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0].kind !== EV_DONE || obs_q[0].data !== 8'hA5) begin
            failures++;
            $display("FAIL single_byte: strobes=%0d first_kind=%0d data=%h required one done with a5",
                     obs_q.size(), (obs_q.size() > 0) ? int'(obs_q[0].kind) : -1,
                     (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
        end
        checks++;
        if (lat < 610 || lat > 613) begin
            failures++;
            $display("FAIL single_latency: latency=%0d clk required 610..613", lat);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_hold: rx_data=%h required a5", rx_data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        time t_edge;
        send_frame(8'h00, 1'b1, 1'b0, t_edge);
        send_frame(8'hFF, 1'b1, 1'b0, t_edge);
        send_frame(8'h3C, 1'b1, 1'b0, t_edge);
        idle_bits(1);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count: strobes=%0d required %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: kind=%0d data=%h required kind=%0d data=%h", i,
                             obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch();
        time t_edge;
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        idle_bits(2);
        checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch: strobes=%0d busy=%b required 0 strobes busy=0", obs_q.size(), busy);
        end
        send_frame(8'h55, 1'b1, 1'b0, t_edge);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0].kind !== EV_DONE || obs_q[0].data !== 8'h55) begin
            failures++;
            $display("FAIL glitch_followup: strobes=%0d data=%h required one done with 55",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_frame_err();
        time        t_edge;
        logic [7:0] prev_good;
        prev_good = last_good;
        send_frame(8'h81, 1'b0, 1'b0, t_edge);
        idle_bits(3);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0].kind !== EV_FERR) begin
            failures++;
            $display("FAIL frame_err: strobes=%0d first_kind=%0d required one frame_err",
                     obs_q.size(), (obs_q.size() > 0) ? int'(obs_q[0].kind) : -1);
        end
        checks++;
        if (rx_data !== prev_good) begin
            failures++;
            $display("FAIL frame_err_hold: rx_data=%h required %h", rx_data, prev_good);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        time t_edge;
        send_frame(8'h07, 1'b1, 1'b1, t_edge);
        send_frame(8'h07, 1'b1, 1'b0, t_edge);
        idle_bits(1);
        checks++;
        if (obs_q.size() !== 2) begin
            failures++;
            $display("FAIL parity_count: strobes=%0d required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].kind !== EV_DONE || obs_q[0].data !== 8'h07) begin
                failures++;
                $display("FAIL parity_good: kind=%0d data=%h required done 07",
                         obs_q[0].kind, obs_q[0].data);
            end
            checks++;
            if (obs_q[1].kind !== EV_PERR) begin
                failures++;
                $display("FAIL parity_bad: kind=%0d required parity_err", obs_q[1].kind);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask
`endif

    task automatic test_random();
        time        t_edge;
        logic [7:0] d;
        int         r;
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 5));
            send_frame(d, (r != 0), (^d) ^ (r == 1), t_edge);
            if (r == 0) idle_bits(3);
        end
        idle_bits(1);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL random_count: strobes=%0d required %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL random_frame%0d: kind=%0d data=%h required kind=%0d data=%h", i,
                             obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        time t_dummy;
        fork
            send_frame(8'h5A, 1'b1, 1'b0, t_dummy);
            begin
                repeat (BIT_CLK * 3) @(posedge clk);
                #2;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL midreset_busy_before: busy=%b required 1", busy);
                end
                reset = 1'b1;
                #1;
                checks++;
                if ({rx_data, rx_done, frame_err, parity_err, busy} !== 12'h000) begin
                    failures++;
                    $display("FAIL midreset_now: outputs=%h required 000",
                             {rx_data, rx_done, frame_err, parity_err, busy});
                end
            end
        join
        reset     = 1'b0;
        last_good = 8'h00;
        exp_q.delete();
        idle_bits(2);
        checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL midreset_after: strobes=%0d busy=%b rx_data=%h required 0 0 00",
                     obs_q.size(), busy, rx_data);
        end
        obs_q.delete();
    endtask

    task automatic test_strobe_width();
        checks++;
        if (width_err !== 0) begin
            failures++;
            $display("FAIL strobe_width: %0d overlong or overlapping strobes, required 0", width_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid_frame();
        test_strobe_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_core
